frame_serializer: RTL and testbench
===================================

# frame_serializer

Parametrised parallel-to-serial converter and successor to the fixed 16×8 task-8 serializer. It accepts a frame of up to `LANES` words of `DATA_W` bits in one cycle and emits the words one per cycle on a valid/ready stream. Each frame can be shortened and its order reversed. Two frame slots form a ping-pong buffer, so the next frame loads while the current one drains, and back-to-back frames leave no idle cycle. It sits between a wide parallel producer and a byte-wide sink that may apply backpressure.

## Interface
- `DATA_W`, default 8: word width.
- `LANES`, default 16: words per full frame (≥2).
- `LEN_W`, default `$clog2(LANES)+1`: width of the length field (derived).

Ports:
- `i_clk`  in  1: single clock, rising edge.
- `i_rst`  in  1: reset, asynchronous, active-high.
- `i_data`  in  `[DATA_W-1:0] x LANES` (unpacked): parallel frame.
- `i_len`  in  `LEN_W`: words to send; 0 or >`LANES` means `LANES`.
- `i_rev`  in  1: 0 sends lane 0 first; 1 sends lane `len-1` first.
- `i_valid`  in  1: frame offered.
- `o_ready`  out  1: a slot is free; frame accepted when `i_valid && o_ready`.
- `o_data`  out  `DATA_W`: serial word.
- `o_valid`  out  1: `o_data` valid.
- `i_ready`  in  1: sink accepts; a word transfers when `o_valid && i_ready`.
- `o_last`  out  1: current word is the final word of its frame.
- `o_busy`  out  1: state is SEND.
- `o_frames`  out  2: occupied slots (0..2).
- `o_frame_cnt`  out  16: completed frames; wraps modulo 2^16.

## Operation
- **Slots.** Two slots, each holding `LANES` words, a clamped length (1..`LANES`) and a rev bit.
  - Write pointer `wp` and read pointer `rp` are 1 bit each.
  - Occupancy `cnt` is 0..2.
  - `o_ready = (cnt != 2)`. There is no same-cycle bypass when full.
- **Load.** On accept, store `i_data`, the clamped `i_len` and `i_rev` into slot `wp`, then toggle `wp`.
- **States.** The state type is {IDLE, SEND}.
  - IDLE: `o_valid=0`. Go to SEND when `cnt != 0`. This includes the cycle after a load into an empty buffer.
  - SEND: `o_valid=1` and `o_data = slot[rp].word[lane]`.
- **Lane index.** Index `idx` runs 0..len-1. `lane = rev ? len-1-idx : idx`.
- **Transfer.** On each transfer, increment `idx`.
- **Last word.** `o_last = (idx == len-1)` while in SEND. When the last word transfers:
  - set `idx` to 0, toggle `rp`, decrement `cnt`, increment `o_frame_cnt`;
  - if the other slot is occupied (`cnt` before decrement == 2, or a load in the same cycle), stay in SEND and present word 0 of the next frame in the following cycle;
  - otherwise go to IDLE.
- **Simultaneous load and free.** `cnt` is unchanged, both pointers toggle, and the state stays SEND.
- **Backpressure.** While `o_valid && !i_ready`, `o_data`, `o_last` and `idx` hold stable. Slot contents are never overwritten while being read.
- **Length-1 frame.** `o_last=1` on its only word.

## Timing
- Load latency: a frame accepted at edge k with the buffer empty gives `o_valid=1` with word 0 during cycle k+2 (one cycle for the slot write, one for the IDLE→SEND transition).
- Throughput: with `i_ready=1` and a frame always pending, `len` words are sent per `len` cycles with no gap between frames.
- `o_data`, `o_last` and `o_valid` are decoded from registers only. There is no combinational path from `i_ready` to `o_valid`/`o_data`, or from `i_valid` to `o_ready`.
- On assertion of `i_rst`, immediately and asynchronously:
  - state = IDLE, `cnt = wp = rp = idx = 0`, `o_frame_cnt = 0`;
  - `o_valid = o_last = o_busy = 0`, `o_data = 0`, `o_frames = 0`;
  - `o_ready = 1` once `cnt` is 0, but loads are ignored while `i_rst` is high.
- Reset in mid-frame discards both slots. No partial frame or `o_last` is emitted afterwards.

## Structure
- Package `frame_serializer_pkg`:
  - state enum {IDLE, SEND};
  - a length-clamp function taking raw length and `LANES`, returning 1..`LANES`.
- Sub-module `frame_serializer_slot`, instantiated twice:
  - holds the word array, length and rev bit;
  - loads on `we`;
  - outputs the word selected by `idx` with rev ordering applied, plus `len`.
- Top level holds the pointers, occupancy, FSM, `idx`, frame counter and output mux.

## Test plan
- **Full frame:** `LANES=16`, `DATA_W=8`, load lanes = 0x10..0x1F, `len=0`, `rev=0`, `i_ready=1` → 0x10..0x1F on 16 consecutive cycles; `o_last` only on 0x1F; `o_frame_cnt=1`; then IDLE.
- **Reversed and short:** same data, `len=4`, `rev=1` → 0x13, 0x12, 0x11, 0x10; `o_last` on 0x10.
- **Back-to-back:** two frames loaded on consecutive cycles (A: 0xA0..0xAF, B: 0xB0..0xBF) → 32 contiguous valid words with no gap between 0xAF and 0xB0; `o_ready=0` only while `cnt=2`; a third frame is refused until A's last word transfers.
- **Backpressure:** toggle `i_ready` every 3 cycles → `o_data` and `o_last` stable while stalled; the output word sequence is identical to the unstalled run.
- **Reset mid-frame:** assert `i_rst` after 5 words of a full frame → outputs zero immediately; after release, a new frame 0xC0.. is sent from 0xC0 with no residue from the old frame.
- **Length edge:** `len=1` → a single word with `o_last=1`; `len=20` (clamped to 16) → 16 words.

Source files
------------

// File: rtl/frame_serializer_pkg.sv
// Shared types and helpers for the parametrised frame serializer.
package frame_serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // A zero length or one beyond the frame size selects a full frame.
  function automatic int unsigned clamp_len(input int unsigned raw_len, input int unsigned lanes);
    int unsigned res;
    if ((raw_len == 32'd0) || (raw_len > lanes)) begin
      res = lanes;
    end else begin
      res = raw_len;
    end
    return res;
  endfunction

endpackage

// File: rtl/frame_serializer_slot.sv
// One frame buffer: word array, clamped length and order bit, with
// order-aware word selection by serial index.
module frame_serializer_slot
  import frame_serializer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 16,
  parameter int LEN_W  = $clog2(LANES) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [DATA_W-1:0] i_data [LANES],
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_rev,
  input  logic [LEN_W-1:0]  i_idx,
  output logic [DATA_W-1:0] o_word,
  output logic [LEN_W-1:0]  o_len
);

  localparam int IDX_W = $clog2(LANES);

  logic [DATA_W-1:0] words_q [LANES];
  logic [LEN_W-1:0]  len_q;
  logic              rev_q;
  logic [IDX_W-1:0]  lane_s;

  // Frame storage, written only when the slot is free and a frame is accepted.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LANES; i++) begin
        words_q[i] <= {DATA_W{1'b0}};
      end
      len_q <= {LEN_W{1'b0}};
      rev_q <= 1'b0;
    end else if (i_we) begin
      words_q <= i_data;
      len_q   <= i_len;
      rev_q   <= i_rev;
    end else begin
      words_q <= words_q;
      len_q   <= len_q;
      rev_q   <= rev_q;
    end
  end

  // Map serial index to physical lane; idx < len keeps the result in range.
  always_comb begin
    lane_s = IDX_W'(rev_q ? (len_q - LEN_W'(1) - i_idx) : i_idx);
  end

  assign o_word = words_q[lane_s];
  assign o_len  = len_q;

endmodule

// File: rtl/frame_serializer.sv
// Ping-pong buffered parallel-to-serial converter with valid/ready output,
// per-frame length and order control.
module frame_serializer
  import frame_serializer_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int LANES  = 16,
  parameter int LEN_W  = $clog2(LANES) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [DATA_W-1:0] i_data [LANES],
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_rev,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_busy,
  output logic [1:0]        o_frames,
  output logic [15:0]       o_frame_cnt
);

  state_e            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              wp_q, wp_d;
  logic              rp_q, rp_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  logic [LEN_W-1:0]  len_clamped_s, len0_s, len1_s, cur_len_s;
  logic [DATA_W-1:0] word0_s, word1_s, cur_word_s;
  logic              accept_s, xfer_s, at_last_s, last_xfer_s, sending_s;

  assign len_clamped_s = LEN_W'(clamp_len(32'(i_len), LANES));

  frame_serializer_slot #(.DATA_W(DATA_W), .LANES(LANES), .LEN_W(LEN_W)) u_slot0 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (accept_s && !wp_q),
    .i_data (i_data),
    .i_len  (len_clamped_s),
    .i_rev  (i_rev),
    .i_idx  (idx_q),
    .o_word (word0_s),
    .o_len  (len0_s)
  );

  frame_serializer_slot #(.DATA_W(DATA_W), .LANES(LANES), .LEN_W(LEN_W)) u_slot1 (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (accept_s && wp_q),
    .i_data (i_data),
    .i_len  (len_clamped_s),
    .i_rev  (i_rev),
    .i_idx  (idx_q),
    .o_word (word1_s),
    .o_len  (len1_s)
  );

  // Handshake decode; everything here depends on registers plus the two input strobes.
  always_comb begin
    sending_s   = (state_q == SEND);
    accept_s    = i_valid && (cnt_q != 2'd2);
    cur_len_s   = rp_q ? len1_s : len0_s;
    cur_word_s  = rp_q ? word1_s : word0_s;
    at_last_s   = (idx_q == (cur_len_s - LEN_W'(1)));
    xfer_s      = sending_s && i_ready;
    last_xfer_s = xfer_s && at_last_s;
  end

  // Next-state for pointers, occupancy, index, counter and FSM.
  always_comb begin
    wp_d        = accept_s ? !wp_q : wp_q;
    rp_d        = last_xfer_s ? !rp_q : rp_q;
    frame_cnt_d = last_xfer_s ? (frame_cnt_q + 16'd1) : frame_cnt_q;

    case ({accept_s, last_xfer_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase

    if (last_xfer_s) begin
      idx_d = {LEN_W{1'b0}};
    end else if (xfer_s) begin
      idx_d = idx_q + LEN_W'(1);
    end else begin
      idx_d = idx_q;
    end

    // Stay in SEND across a frame boundary whenever the other slot holds a frame.
    case (state_q)
      IDLE:    state_d = (cnt_q != 2'd0) ? SEND : IDLE;
      SEND:    state_d = (last_xfer_s && (cnt_q != 2'd2) && !accept_s) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // Control state registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      idx_q       <= {LEN_W{1'b0}};
      frame_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign o_ready     = (cnt_q != 2'd2);
  assign o_valid     = sending_s;
  assign o_busy      = sending_s;
  assign o_last      = sending_s && at_last_s;
  assign o_data      = sending_s ? cur_word_s : {DATA_W{1'b0}};
  assign o_frames    = cnt_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed self-checking bench for frame_serializer (DATA_W=8, LANES=16).
module tb_frame_serializer;

  logic        i_clk;
  logic        i_rst;
  logic [7:0]  i_data [16];
  logic [4:0]  i_len;
  logic        i_rev;
  logic        i_valid;
  logic        o_ready;
  logic [7:0]  o_data;
  logic        o_valid;
  logic        i_ready;
  logic        o_last;
  logic        o_busy;
  logic [1:0]  o_frames;
  logic [15:0] o_frame_cnt;

  int checks = 0;
  int errors = 0;

  frame_serializer #(.DATA_W(8), .LANES(16)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data      (i_data),
    .i_len       (i_len),
    .i_rev       (i_rev),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_last      (o_last),
    .o_busy      (o_busy),
    .o_frames    (o_frames),
    .o_frame_cnt (o_frame_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Called at a negedge; offers one frame across the next posedge, returns at the following negedge.
  task automatic send_frame(input logic [7:0] base, input logic [4:0] len, input logic rev);
    for (int i = 0; i < 16; i++) i_data[i] = base + 8'(i);
    i_len   = len;
    i_rev   = rev;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    #1;
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", o_valid); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b expected 1", o_ready); end
    checks++; if (o_frames !== 2'd0) begin errors++; $display("FAIL rst_frames: got %0d expected 0", o_frames); end
    checks++; if (o_frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt: got %0d expected 0", o_frame_cnt); end
    checks++; if (o_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h expected 00", o_data); end
    checks++; if (o_last !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL rst_last_busy: got %b%b expected 00", o_last, o_busy); end
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic test_full_frame;
    send_frame(8'h10, 5'd0, 1'b0);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL full_latency: got valid %b expected 0", o_valid); end
    @(negedge i_clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h10 + 8'(i) || o_last !== (i == 15)) begin
        errors++;
        $display("FAIL full_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", i, o_valid, o_data, o_last, 8'h10 + 8'(i), (i == 15));
      end
      @(negedge i_clk);
    end
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0) begin errors++; $display("FAIL full_idle: got v=%b b=%b expected 0 0", o_valid, o_busy); end
    checks++; if (o_frame_cnt !== 16'd1) begin errors++; $display("FAIL full_frame_cnt: got %0d expected 1", o_frame_cnt); end
  endtask

  task automatic test_rev_short;
    send_frame(8'h10, 5'd4, 1'b1);
    @(negedge i_clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h13 - 8'(i) || o_last !== (i == 3)) begin
        errors++;
        $display("FAIL rev_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", i, o_valid, o_data, o_last, 8'h13 - 8'(i), (i == 3));
      end
      @(negedge i_clk);
    end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rev_idle: got %b expected 0", o_valid); end
    checks++; if (o_frame_cnt !== 16'd2) begin errors++; $display("FAIL rev_frame_cnt: got %0d expected 2", o_frame_cnt); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp;
    bit c_pending;
    bit c_taken;
    send_frame(8'hA0, 5'd0, 1'b0);
    send_frame(8'hB0, 5'd0, 1'b0);
    for (int i = 0; i < 16; i++) i_data[i] = 8'hD0 + 8'(i);
    i_len = 5'd0; i_rev = 1'b0; i_valid = 1'b1;
    c_pending = 1'b1;
    for (int i = 0; i < 48; i++) begin
      if (i < 16) exp = 8'hA0 + 8'(i);
      else if (i < 32) exp = 8'hB0 + 8'(i - 16);
      else exp = 8'hD0 + 8'(i - 32);
      checks++;
      if (o_valid !== 1'b1 || o_data !== exp || o_last !== ((i % 16) == 15)) begin
        errors++;
        $display("FAIL b2b_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", i, o_valid, o_data, o_last, exp, ((i % 16) == 15));
      end
      if (i <= 16) begin
        checks++;
        if (o_ready !== (i == 16)) begin errors++; $display("FAIL b2b_ready%0d: got %b expected %b", i, o_ready, (i == 16)); end
      end
      c_taken = c_pending && (o_ready === 1'b1);
      @(negedge i_clk);
      if (c_taken) begin
        i_valid = 1'b0;
        c_pending = 1'b0;
      end
    end
    i_valid = 1'b0;
    checks++; if (c_pending) begin errors++; $display("FAIL b2b_third_accept: got pending expected accepted"); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b expected 0", o_valid); end
    checks++; if (o_frame_cnt !== 16'd5) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected 5", o_frame_cnt); end
  endtask

  task automatic test_backpressure;
    int n;
    int cyc;
    logic [7:0] prev_d;
    logic prev_l;
    bit stalled;
    send_frame(8'h10, 5'd0, 1'b0);
    n = 0; cyc = 0; stalled = 1'b0; prev_d = 8'h00; prev_l = 1'b0;
    while (n < 16 && cyc < 200) begin
      if (stalled) begin
        checks++;
        if (o_valid !== 1'b1 || o_data !== prev_d || o_last !== prev_l) begin
          errors++;
          $display("FAIL bp_hold%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", cyc, o_valid, o_data, o_last, prev_d, prev_l);
        end
      end
      i_ready = (((cyc / 3) % 2) == 0);
      if (o_valid === 1'b1) begin
        if (i_ready) begin
          checks++;
          if (o_data !== 8'h10 + 8'(n) || o_last !== (n == 15)) begin
            errors++;
            $display("FAIL bp_word%0d: got d=%h l=%b expected d=%h l=%b", n, o_data, o_last, 8'h10 + 8'(n), (n == 15));
          end
          n++;
        end
        stalled = !i_ready;
      end else begin
        stalled = 1'b0;
      end
      prev_d = o_data;
      prev_l = o_last;
      cyc++;
      @(negedge i_clk);
    end
    i_ready = 1'b1;
    checks++; if (n != 16) begin errors++; $display("FAIL bp_timeout: got %0d words expected 16", n); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL bp_idle: got %b expected 0", o_valid); end
    checks++; if (o_frame_cnt !== 16'd6) begin errors++; $display("FAIL bp_frame_cnt: got %0d expected 6", o_frame_cnt); end
  endtask

  task automatic test_reset_mid;
    send_frame(8'h10, 5'd0, 1'b0);
    send_frame(8'h20, 5'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (o_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL rm_pre%0d: got %h expected %h", i, o_data, 8'h10 + 8'(i)); end
      @(negedge i_clk);
    end
    checks++; if (o_data !== 8'h15 || o_frames !== 2'd2) begin errors++; $display("FAIL rm_before: got d=%h f=%0d expected d=15 f=2", o_data, o_frames); end
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_data !== 8'h00 || o_last !== 1'b0 || o_busy !== 1'b0 || o_frames !== 2'd0 || o_frame_cnt !== 16'd0) begin
      errors++;
      $display("FAIL rm_async: got v=%b d=%h l=%b b=%b f=%0d c=%0d expected all zero", o_valid, o_data, o_last, o_busy, o_frames, o_frame_cnt);
    end
    for (int i = 0; i < 16; i++) i_data[i] = 8'h30 + 8'(i);
    i_valid = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (o_valid !== 1'b0 || o_frames !== 2'd0 || o_ready !== 1'b1) begin
        errors++;
        $display("FAIL rm_quiet%0d: got v=%b f=%0d r=%b expected v=0 f=0 r=1", i, o_valid, o_frames, o_ready);
      end
      @(negedge i_clk);
    end
    send_frame(8'hC0, 5'd0, 1'b0);
    @(negedge i_clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'hC0 + 8'(i) || o_last !== (i == 15)) begin
        errors++;
        $display("FAIL rm_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", i, o_valid, o_data, o_last, 8'hC0 + 8'(i), (i == 15));
      end
      @(negedge i_clk);
    end
    checks++; if (o_valid !== 1'b0 || o_frame_cnt !== 16'd1) begin errors++; $display("FAIL rm_after: got v=%b c=%0d expected v=0 c=1", o_valid, o_frame_cnt); end
  endtask

  task automatic test_len_edge;
    send_frame(8'h40, 5'd1, 1'b0);
    @(negedge i_clk);
    checks++;
    if (o_valid !== 1'b1 || o_data !== 8'h40 || o_last !== 1'b1) begin
      errors++;
      $display("FAIL len1_word: got v=%b d=%h l=%b expected v=1 d=40 l=1", o_valid, o_data, o_last);
    end
    @(negedge i_clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL len1_idle: got %b expected 0", o_valid); end
    send_frame(8'h50, 5'd20, 1'b0);
    @(negedge i_clk);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (o_valid !== 1'b1 || o_data !== 8'h50 + 8'(i) || o_last !== (i == 15)) begin
        errors++;
        $display("FAIL len20_word%0d: got v=%b d=%h l=%b expected v=1 d=%h l=%b", i, o_valid, o_data, o_last, 8'h50 + 8'(i), (i == 15));
      end
      @(negedge i_clk);
    end
    checks++; if (o_valid !== 1'b0 || o_frame_cnt !== 16'd3) begin errors++; $display("FAIL len20_after: got v=%b c=%0d expected v=0 c=3", o_valid, o_frame_cnt); end
  endtask

  initial begin
    i_rst = 1'b0;
    i_len = 5'd0;
    i_rev = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    for (int i = 0; i < 16; i++) i_data[i] = 8'h00;
    #1;
    test_reset;
    test_full_frame;
    test_rev_short;
    test_back_to_back;
    test_backpressure;
    test_reset_mid;
    test_len_edge;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
